fetch_queue_unit: RTL and testbench
===================================

Name: fetch_queue_unit

Overview:
- Parametrised successor to the current front-front fetch stage.
- Generates sequential PCs, issues instruction-memory requests with one request outstanding and variable response latency, and buffers fetched {addr, inst} pairs in a DEPTH-entry FIFO toward decode.
- Handles jumps by flushing the queue and discarding stale in-flight responses.
- Sits between the PC source and the decode stage in the core front end.

Parameters:
- ADDR_W, 32, instruction address width
- INST_W, 32, instruction width
- DEPTH, 4, queue entries (power of two, >=2)
- PC_STEP, 4, address increment per fetch
- RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- jump_flag_i  in  1  redirect request, single-cycle
- jump_addr_i  in  ADDR_W  redirect target
- req_o  out  1  memory request valid (registered)
- req_addr_o  out  ADDR_W  request address (registered, stable while req_o=1)
- data_ok_i  in  1  memory response valid; completes the current request
- inst_fetch_i  in  INST_W  response data, valid when data_ok_i=1
- valid_o  out  1  queue head valid to decode
- ready_i  in  1  decode accepts head
- inst_o  out  INST_W  head instruction
- inst_addr_o  out  ADDR_W  head instruction address

Behaviour:
Reset values:
- req_o=0, req_addr_o=RESET_PC, pc=RESET_PC
- queue empty, so valid_o=0 and inst_o/inst_addr_o=0
- state IDLE

Request issue:
- Issue only when occupancy + outstanding < DEPTH; slots are reserved, so a response is never dropped for lack of space.

State machine (IDLE / WAIT / DROP):
- IDLE, space available, no jump: next edge req_o=1, req_addr_o=pc, go to WAIT. The first request appears on the 2nd rising edge after reset deasserts.
- WAIT, data_ok_i=1, no jump: push {req_addr_o, inst_fetch_i}; pc += PC_STEP (wraps modulo 2^ADDR_W).
  - If space remains (accounting for the same-cycle pop), stay in WAIT with req_addr_o=new pc, giving back-to-back requests.
  - Otherwise req_o=0 and go to IDLE.
- WAIT, jump_flag_i=1, data_ok_i=0: req_o=0, pc=jump_addr_i, go to DROP.
- WAIT, jump_flag_i=1, data_ok_i=1: discard the response, req_o=1, req_addr_o=jump_addr_i, stay in WAIT.
- DROP: wait for data_ok_i, discard the data, then issue jump_addr_i (or the latest target if another jump arrives in DROP); go to WAIT.
- IDLE, jump_flag_i=1: pc=jump_addr_i; request it next edge if space.

Jump flush:
- Queue emptied at the same edge.
- valid_o is masked to 0 combinationally while jump_flag_i=1; no pop happens that cycle even if ready_i=1.

Queue:
- Pop on valid_o & ready_i.
- Push and pop in the same cycle keep occupancy unchanged.
- Full: req_o stays 0 until a pop.
- Empty: valid_o=0.
- No combinational bypass: a response at edge N gives valid_o=1 in the cycle after N.

Memory protocol:
- data_ok_i while no request is outstanding is ignored.

Reset mid-operation:
- Immediately returns every output to its reset value; an in-flight response arriving after reset is ignored.

Optional Feature:
- Macro FETCH_QUEUE_STAT_EN adds:
  - stat_fetch_cnt_o (out, 32): counts accepted pushes.
  - stat_drop_cnt_o (out, 32): counts discarded responses and flushed entries; a flush of k entries adds k.
- Both counters reset to 0 and wrap at 2^32.
- Without the macro, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
1. Reset release, ready_i=1, memory returns data_ok_i 1 cycle after each req_o:
   - req_addr_o sequence 0x0, 0x4, 0x8.
   - valid_o carries inst_addr_o 0x0, 0x4, 0x8 with matching inst_o.
   - No gaps once streaming.
2. ready_i=0, DEPTH=4:
   - Exactly 4 responses are pushed, then req_o=0 and stays 0.
   - One pop with ready_i=1 for one cycle gives exactly one new request, to 0x10.
3. Jump to 0x100 while a request to 0x8 is outstanding; data_ok_i arrives 3 cycles later with 0xDEAD:
   - 0xDEAD is discarded.
   - The next req_addr_o is 0x100.
   - Queue is empty at the jump edge.
   - First valid_o after the jump has inst_addr_o=0x100.
4. jump_flag_i and data_ok_i in the same cycle, target 0x200:
   - The response is discarded.
   - req_o=1 with req_addr_o=0x200 at the next edge.
   - valid_o=0 during the jump cycle.
5. Assert reset in WAIT with 2 queued entries, release, then feed a late data_ok_i:
   - valid_o=0 and req_o=0 immediately.
   - The late response is ignored.
   - Fetch restarts at RESET_PC.
6. With FETCH_QUEUE_STAT_EN, run scenario 3 with 2 entries queued at the jump:
   - stat_drop_cnt_o=3.
   - stat_fetch_cnt_o equals the number of pushes made.

Source files
------------

// File: rtl/fetch_queue_unit.sv
// Front-end fetch stage: sequential PC generation, one outstanding imem request, DEPTH-entry {addr, inst} queue to decode.
// Optional statistics counters are compiled in with FETCH_QUEUE_STAT_EN.
module fetch_queue_unit #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INST_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter int unsigned       PC_STEP  = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              jump_flag_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    output logic              req_o,
    output logic [ADDR_W-1:0] req_addr_o,
    input  logic              data_ok_i,
    input  logic [INST_W-1:0] inst_fetch_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_addr_o
`ifdef FETCH_QUEUE_STAT_EN
    ,
    output logic [31:0]       stat_fetch_cnt_o,
    output logic [31:0]       stat_drop_cnt_o
`endif
);

    localparam int unsigned       PTR_W   = $clog2(DEPTH);
    localparam int unsigned       CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] STEP_C  = ADDR_W'(PC_STEP);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              init_q;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];

    logic              not_empty;
    logic              push;
    logic              pop;
    logic              flush;
    logic              discard;
    logic              has_space;
    logic [ADDR_W-1:0] next_pc;

    // Decode handshake: the head transfers on any edge where valid_o && ready_i;
    // valid_o never depends on ready_i, and a redirect masks valid_o for that cycle.
    assign not_empty   = (count_q != '0);
    assign valid_o     = not_empty & ~jump_flag_i;
    assign pop         = valid_o & ready_i;
    assign flush       = jump_flag_i;
    assign push        = (state_q == S_WAIT) & data_ok_i & ~jump_flag_i;
    assign discard     = data_ok_i & ((state_q == S_DROP) |
                                      ((state_q == S_WAIT) & jump_flag_i));
    assign inst_o      = not_empty ? inst_mem[rd_ptr_q] : '0;
    assign inst_addr_o = not_empty ? addr_mem[rd_ptr_q] : '0;
    assign req_o       = req_q;
    assign req_addr_o  = req_addr_q;
    assign next_pc     = pc_q + STEP_C;

    // Occupancy after this edge; a new request is only issued if it can land.
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
        end
    end

    assign has_space = (count_d < DEPTH_C);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_d      = req_q;
        req_addr_d = req_addr_q;
        case (state_q)
            S_IDLE: begin
                if (jump_flag_i) begin
                    pc_d = jump_addr_i;
                end
                if (init_q && has_space) begin
                    req_d      = 1'b1;
                    req_addr_d = jump_flag_i ? jump_addr_i : pc_q;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (jump_flag_i) begin
                    pc_d = jump_addr_i;
                    if (data_ok_i) begin
                        req_addr_d = jump_addr_i;
                    end else begin
                        req_d   = 1'b0;
                        state_d = S_DROP;
                    end
                end else if (data_ok_i) begin
                    pc_d = next_pc;
                    if (has_space) begin
                        req_addr_d = next_pc;
                    end else begin
                        req_d   = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
            S_DROP: begin
                // The stale response must come back before the target can be requested.
                if (jump_flag_i) begin
                    pc_d = jump_addr_i;
                end
                if (data_ok_i) begin
                    req_d      = 1'b1;
                    req_addr_d = jump_flag_i ? jump_addr_i : pc_q;
                    pc_d       = jump_flag_i ? jump_addr_i : pc_q;
                    state_d    = S_WAIT;
                end
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            init_q     <= 1'b0;
            pc_q       <= RESET_PC;
            req_q      <= 1'b0;
            req_addr_q <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            init_q     <= 1'b1;
            pc_q       <= pc_d;
            req_q      <= req_d;
            req_addr_q <= req_addr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_q] <= req_addr_q;
            inst_mem[wr_ptr_q] <= inst_fetch_i;
        end
    end

`ifdef FETCH_QUEUE_STAT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] drop_cnt_q;

    // A flush of k live entries counts as k drops, on top of any discarded response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_q + 32'(push);
            drop_cnt_q  <= drop_cnt_q + 32'(discard) + (flush ? 32'(count_q) : 32'd0);
        end
    end

    assign stat_fetch_cnt_o = fetch_cnt_q;
    assign stat_drop_cnt_o  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: streaming, full queue, jumps, reset mid-flight, PC wrap.
// Statistics checks are included when FETCH_QUEUE_STAT_EN is defined.
module tb_fetch_queue_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        jump_flag_i = 1'b0;
    logic [31:0] jump_addr_i = '0;
    logic        req_o;
    logic [31:0] req_addr_o;
    logic        data_ok_i = 1'b0;
    logic [31:0] inst_fetch_i = '0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
`ifdef FETCH_QUEUE_STAT_EN
    logic [31:0] stat_fetch_cnt_o;
    logic [31:0] stat_drop_cnt_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    bit mem_auto = 1'b0;
    int mem_lat  = 1;
    int mem_cnt  = 0;

    always #5 clk = ~clk;

    fetch_queue_unit #(
        .ADDR_W  (32),
        .INST_W  (32),
        .DEPTH   (4),
        .PC_STEP (4),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .jump_flag_i (jump_flag_i),
        .jump_addr_i (jump_addr_i),
        .req_o       (req_o),
        .req_addr_o  (req_addr_o),
        .data_ok_i   (data_ok_i),
        .inst_fetch_i(inst_fetch_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .inst_o      (inst_o),
        .inst_addr_o (inst_addr_o)
`ifdef FETCH_QUEUE_STAT_EN
        ,
        .stat_fetch_cnt_o(stat_fetch_cnt_o),
        .stat_drop_cnt_o (stat_drop_cnt_o)
`endif
    );

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory model: answers the current request after mem_lat cycles of req_o.
    task automatic mem_step();
        if (mem_auto) begin
            if (data_ok_i) begin
                data_ok_i = 1'b0;
                mem_cnt   = 0;
            end
            if (req_o) begin
                mem_cnt++;
                if (mem_cnt >= mem_lat) begin
                    data_ok_i    = 1'b1;
                    inst_fetch_i = inst_of(req_addr_o);
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        mem_step();
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        jump_flag_i = 1'b0;
        data_ok_i   = 1'b0;
        ready_i     = 1'b0;
        mem_auto    = 1'b0;
        mem_cnt     = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic check_stats(input string tag, input int fetches, input int drops);
`ifdef FETCH_QUEUE_STAT_EN
        check_eq({tag, "_fetch_cnt"}, stat_fetch_cnt_o, fetches);
        check_eq({tag, "_drop_cnt"}, stat_drop_cnt_o, drops);
`endif
    endtask

    initial begin
        // Reset state and streaming with one-cycle memory latency.
        do_reset();
        check_eq("rst_req", req_o, 0);
        check_eq("rst_req_addr", req_addr_o, 32'h0);
        check_eq("rst_valid", valid_o, 0);
        check_eq("rst_inst", inst_o, 0);
        check_eq("rst_inst_addr", inst_addr_o, 0);
        check_stats("rst", 0, 0);
        ready_i  = 1'b1;
        mem_auto = 1'b1;
        tick();
        check_eq("t1_no_req_edge1", req_o, 0);
        tick();
        check_eq("t1_req_edge2", req_o, 1);
        check_eq("t1_req_addr0", req_addr_o, 32'h0);
        check_eq("t1_valid_before", valid_o, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq($sformatf("t1_valid%0d", i), valid_o, 1);
            check_eq($sformatf("t1_head_addr%0d", i), inst_addr_o, 32'(4 * i));
            check_eq($sformatf("t1_head_inst%0d", i), inst_o, inst_of(32'(4 * i)));
            check_eq($sformatf("t1_req_addr%0d", i), req_addr_o, 32'(4 * (i + 1)));
        end

        // Decode stalled: exactly four pushes, then one pop frees one request.
        do_reset();
        mem_auto = 1'b1;
        repeat (6) tick();
        check_eq("t2_req_off_full", req_o, 0);
        check_eq("t2_head_valid", valid_o, 1);
        check_eq("t2_head_addr", inst_addr_o, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq($sformatf("t2_req_stays0_%0d", i), req_o, 0);
        end
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        check_eq("t2_req_after_pop", req_o, 1);
        check_eq("t2_req_addr_after_pop", req_addr_o, 32'h10);
        check_eq("t2_head_after_pop", inst_addr_o, 32'h4);
        tick();
        check_eq("t2_req_off_again", req_o, 0);
        tick();
        check_eq("t2_req_still_off", req_o, 0);
        mem_auto  = 1'b0;
        data_ok_i = 1'b0;
        exp_q = {32'h4, 32'h8, 32'hC, 32'h10};
        ready_i = 1'b1;
        #1;
        while (exp_q.size() > 0) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            check_eq("t2_drain_valid", valid_o, 1);
            check_eq("t2_drain_addr", inst_addr_o, e);
            check_eq("t2_drain_inst", inst_o, inst_of(e));
            tick();
        end
        check_eq("t2_drained_empty", valid_o, 0);
        ready_i = 1'b0;

        // Jump with a request outstanding; stale response arrives later.
        do_reset();
        mem_auto = 1'b1;
        repeat (4) tick();
        mem_auto  = 1'b0;
        data_ok_i = 1'b0;
        check_eq("t3_req_out", req_o, 1);
        check_eq("t3_req_addr8", req_addr_o, 32'h8);
        check_eq("t3_two_queued_head", inst_addr_o, 32'h0);
        jump_flag_i = 1'b1;
        jump_addr_i = 32'h100;
        #1;
        check_eq("t3_valid_masked", valid_o, 0);
        tick();
        jump_flag_i = 1'b0;
        #1;
        check_eq("t3_req_off_drop", req_o, 0);
        check_eq("t3_flushed", valid_o, 0);
        check_eq("t3_flushed_addr", inst_addr_o, 0);
        tick();
        tick();
        check_eq("t3_still_drop", req_o, 0);
        data_ok_i    = 1'b1;
        inst_fetch_i = 32'h0000_DEAD;
        tick();
        data_ok_i = 1'b0;
        check_eq("t3_req_target", req_o, 1);
        check_eq("t3_req_addr_target", req_addr_o, 32'h100);
        check_eq("t3_dead_discarded", valid_o, 0);
        data_ok_i    = 1'b1;
        inst_fetch_i = inst_of(32'h100);
        tick();
        data_ok_i = 1'b0;
        #1;
        check_eq("t3_first_valid", valid_o, 1);
        check_eq("t3_first_addr", inst_addr_o, 32'h100);
        check_eq("t3_first_inst", inst_o, inst_of(32'h100));
        check_eq("t3_next_req_addr", req_addr_o, 32'h104);
        check_stats("t3", 3, 3);

        // Jump and response in the same cycle.
        data_ok_i    = 1'b1;
        inst_fetch_i = 32'h0000_BEEF;
        jump_flag_i  = 1'b1;
        jump_addr_i  = 32'h200;
        #1;
        check_eq("t4_valid_masked", valid_o, 0);
        tick();
        jump_flag_i = 1'b0;
        data_ok_i   = 1'b0;
        #1;
        check_eq("t4_req", req_o, 1);
        check_eq("t4_req_addr", req_addr_o, 32'h200);
        check_eq("t4_flushed", valid_o, 0);
        data_ok_i    = 1'b1;
        inst_fetch_i = inst_of(32'h200);
        tick();
        data_ok_i = 1'b0;
        #1;
        check_eq("t4_head_valid", valid_o, 1);
        check_eq("t4_head_addr", inst_addr_o, 32'h200);
        check_eq("t4_head_inst", inst_o, inst_of(32'h200));
        check_stats("t4", 4, 5);

        // Reset while waiting with two entries queued; late response ignored.
        data_ok_i    = 1'b1;
        inst_fetch_i = inst_of(32'h204);
        tick();
        data_ok_i = 1'b0;
        #1;
        check_eq("t5_two_queued", valid_o, 1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("t5_rst_valid", valid_o, 0);
        check_eq("t5_rst_req", req_o, 0);
        check_eq("t5_rst_req_addr", req_addr_o, 32'h0);
        check_eq("t5_rst_inst_addr", inst_addr_o, 0);
        check_stats("t5_rst", 0, 0);
        repeat (2) @(posedge clk);
        #1;
        reset        = 1'b0;
        data_ok_i    = 1'b1;
        inst_fetch_i = 32'h0000_0BAD;
        tick();
        data_ok_i = 1'b0;
        #1;
        check_eq("t5_late_ignored", valid_o, 0);
        check_eq("t5_no_req_yet", req_o, 0);
        tick();
        check_eq("t5_restart_req", req_o, 1);
        check_eq("t5_restart_addr", req_addr_o, 32'h0);
        check_eq("t5_still_empty", valid_o, 0);
        check_stats("t5", 0, 0);

        // PC increment wraps at the top of the address space.
        jump_flag_i  = 1'b1;
        jump_addr_i  = 32'hFFFF_FFFC;
        data_ok_i    = 1'b1;
        inst_fetch_i = 32'h0000_1111;
        tick();
        jump_flag_i  = 1'b0;
        inst_fetch_i = inst_of(32'hFFFF_FFFC);
        #1;
        check_eq("wrap_req_addr", req_addr_o, 32'hFFFF_FFFC);
        tick();
        data_ok_i = 1'b0;
        #1;
        check_eq("wrap_head_addr", inst_addr_o, 32'hFFFF_FFFC);
        check_eq("wrap_next_req", req_o, 1);
        check_eq("wrap_next_addr", req_addr_o, 32'h0);
        check_stats("wrap", 1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
